// File: rtl/multi_pattern_detector_pkg.sv
// Shared defaults and helpers for the multi-lane serial pattern detector.
// Counter helper works on up to SAT_W-bit counters.
package multi_pattern_detector_pkg;

  localparam int DEF_PAT_LEN = 3;
  localparam int DEF_NUM_PAT = 2;
  localparam int DEF_CNT_W   = 8;
  localparam int SAT_W       = 32;

  // Lane 0 = 111, lane 1 = 001
  localparam logic [DEF_NUM_PAT*DEF_PAT_LEN-1:0] DEF_RESET_PATTERNS = 6'b001_111;

  // Increment value, holding at the all-ones value of a width-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input int unsigned      width);
    logic [63:0] limit;
    limit = (64'd1 << width) - 64'd1;
    if (64'(value) >= limit) return value;
    return value + SAT_W'(1);
  endfunction

endpackage

// File: rtl/pattern_match_lane.sv
// One detector lane: pattern register, comparator, sticky flag and
// saturating match counter. The hit output is combinational (Mealy).
module pattern_match_lane
  import multi_pattern_detector_pkg::*;
#(
  parameter int                 PAT_LEN       = DEF_PAT_LEN,
  parameter int                 CNT_W         = DEF_CNT_W,
  parameter logic [PAT_LEN-1:0] RESET_PATTERN = '1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [PAT_LEN-1:0] window,
  input  logic               window_ok,
  input  logic               clear,
  input  logic               load,
  input  logic [PAT_LEN-1:0] load_pattern,
  output logic               hit,
  output logic               seen,
  output logic [CNT_W-1:0]   count
);

  logic [PAT_LEN-1:0] pattern_reg, pattern_next;
  logic               seen_reg, seen_next;
  logic [CNT_W-1:0]   count_reg, count_next;

  // Compares against the registered pattern, so a same-cycle load is not seen yet
  assign hit = window_ok && (window == pattern_reg);

  always_comb begin
    pattern_next = load ? load_pattern : pattern_reg;
    seen_next    = seen_reg;
    count_next   = count_reg;
    if (clear) begin
      seen_next  = 1'b0;
      count_next = '0;
    end else if (hit) begin
      seen_next  = 1'b1;
      count_next = CNT_W'(sat_inc(SAT_W'(count_reg), CNT_W));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pattern_reg <= RESET_PATTERN;
      seen_reg    <= 1'b0;
      count_reg   <= '0;
    end else begin
      pattern_reg <= pattern_next;
      seen_reg    <= seen_next;
      count_reg   <= count_next;
    end
  end

  assign seen  = seen_reg;
  assign count = count_reg;

endmodule

// File: rtl/multi_pattern_detector.sv
// Serial multi-pattern detector: shared bit history and fill tracking,
// with one pattern_match_lane per pattern and a config write decoder.
module multi_pattern_detector
  import multi_pattern_detector_pkg::*;
#(
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter int NUM_PAT = DEF_NUM_PAT,
  parameter int CNT_W   = DEF_CNT_W,
  parameter logic [NUM_PAT*PAT_LEN-1:0] RESET_PATTERNS =
    (NUM_PAT*PAT_LEN)'(DEF_RESET_PATTERNS),
  localparam int IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     i,
  input  logic                     valid_in,
  input  logic                     clear,
  input  logic                     cfg_we,
  input  logic [IDX_W-1:0]         cfg_idx,
  input  logic [PAT_LEN-1:0]       cfg_pattern,
  output logic [NUM_PAT-1:0]       hit,
  output logic [NUM_PAT-1:0]       seen,
  output logic [NUM_PAT*CNT_W-1:0] count
);

  localparam int FILL_W = $clog2(PAT_LEN);

  logic [PAT_LEN-2:0] history_reg, history_next;
  logic [FILL_W-1:0]  fill_reg, fill_next;
  logic [PAT_LEN-1:0] window;
  logic               history_full;
  logic               window_ok;

  // Oldest bit sits in the MSB; the live input bit completes the window
  assign window       = {history_reg, i};
  assign history_full = (fill_reg == FILL_W'(PAT_LEN - 1));
  assign window_ok    = valid_in && history_full;

  always_comb begin
    history_next = history_reg;
    fill_next    = fill_reg;
    if (valid_in) begin
      history_next = window[PAT_LEN-2:0];
      if (!history_full) fill_next = fill_reg + FILL_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      history_reg <= '0;
      fill_reg    <= '0;
    end else begin
      history_reg <= history_next;
      fill_reg    <= fill_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_lane
      logic lane_we;
      // Out-of-range indices match no lane, so such writes are dropped
      assign lane_we = cfg_we && (cfg_idx == IDX_W'(gi));

      pattern_match_lane #(
        .PAT_LEN       (PAT_LEN),
        .CNT_W         (CNT_W),
        .RESET_PATTERN (RESET_PATTERNS[gi*PAT_LEN +: PAT_LEN])
      ) u_lane (
        .clock        (clock),
        .reset_n      (reset_n),
        .window       (window),
        .window_ok    (window_ok),
        .clear        (clear),
        .load         (lane_we),
        .load_pattern (cfg_pattern),
        .hit          (hit[gi]),
        .seen         (seen[gi]),
        .count        (count[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_pattern_detector.sv
// Directed vector bench for multi_pattern_detector (default lanes 111/001),
// plus a second CNT_W=2 instance for counter saturation.
module tb_multi_pattern_detector;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       i = 1'b0;
  logic       valid_in = 1'b0;
  logic       clear = 1'b0;
  logic       cfg_we = 1'b0;
  logic [0:0] cfg_idx = 1'b0;
  logic [2:0] cfg_pattern = 3'b000;
  logic [1:0] hit, seen, hit2, seen2;
  logic [15:0] count;
  logic [3:0]  count2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  multi_pattern_detector dut (
    .clock(clock), .reset_n(reset_n), .i(i), .valid_in(valid_in),
    .clear(clear), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pattern(cfg_pattern), .hit(hit), .seen(seen), .count(count)
  );

  multi_pattern_detector #(.CNT_W(2)) dut_sat (
    .clock(clock), .reset_n(reset_n), .i(i), .valid_in(valid_in),
    .clear(clear), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_pattern(cfg_pattern), .hit(hit2), .seen(seen2), .count(count2)
  );

  typedef struct {
    logic       rst_n;
    logic       v;
    logic       b;
    logic       clr;
    logic       we;
    logic       idx;
    logic [2:0] pat;
    logic [1:0] hit;
    logic [1:0] seen;
    logic [7:0] c0;
    logic [7:0] c1;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic v, logic b, logic clr, logic we,
                              logic idx, logic [2:0] pat, logic [1:0] h,
                              logic [1:0] s, logic [7:0] c0, logic [7:0] c1);
    vec_t t;
    t.rst_n = r; t.v = v; t.b = b; t.clr = clr; t.we = we; t.idx = idx;
    t.pat = pat; t.hit = h; t.seen = s; t.c0 = c0; t.c1 = c1;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, check hit before the rising edge, state after it
  task automatic apply(input vec_t t, input int n);
    @(negedge clock);
    reset_n = t.rst_n; valid_in = t.v; i = t.b; clear = t.clr;
    cfg_we = t.we; cfg_idx = t.idx; cfg_pattern = t.pat;
    #1;
    check($sformatf("vec%0d_hit", n), 32'(hit), 32'(t.hit));
    @(posedge clock);
    #1;
    check($sformatf("vec%0d_seen", n), 32'(seen), 32'(t.seen));
    check($sformatf("vec%0d_count0", n), 32'(count[7:0]), 32'(t.c0));
    check($sformatf("vec%0d_count1", n), 32'(count[15:8]), 32'(t.c1));
    $display("vec %0d rst_n=%b v=%b i=%b clr=%b we=%b hit=%b seen=%b c0=%0d c1=%0d",
             n, t.rst_n, t.v, t.b, t.clr, t.we, hit, seen, count[7:0], count[15:8]);
  endtask

  initial begin
    //                 rst v  b  clr we idx pat     hit    seen   c0 c1
    // first bit after reset never hits
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    // 0,0,1 hits lane1 only; then 1,1 completes 111 on lane0
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 3'b000, 2'b10, 2'b10, 0, 1));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 3'b000, 2'b00, 2'b10, 0, 1));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 3'b000, 2'b01, 2'b11, 1, 1));
    // 1,1,<invalid 0>,1 hits lane0; invalid bit ignored
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 3'b000, 2'b01, 2'b01, 1, 0));
    vq.push_back(mk(1, 0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b01, 1, 0));
    // write lane0=101: same-cycle hit uses old 111, new pattern from next cycle
    vq.push_back(mk(1, 1, 1, 0, 1, 0, 3'b101, 2'b01, 2'b01, 2, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b01, 2, 0));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 3'b000, 2'b01, 2'b01, 3, 0));
    // write lane1=110 leaves seen/count/history alone
    vq.push_back(mk(1, 0, 0, 0, 1, 1, 3'b110, 2'b00, 2'b01, 3, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b01, 3, 0));
    // clear coincident with a 101 match: hit still shows, state zeroed
    vq.push_back(mk(1, 1, 1, 1, 0, 0, 3'b000, 2'b01, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 3'b000, 2'b10, 2'b10, 0, 1));
    // mid-stream reset discards 0,0 history and restores patterns 111/001
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 3'b000, 2'b01, 2'b01, 1, 0));

    for (int n = 0; n < vq.size(); n++) apply(vq[n], n);

    // Seven 1s: lane0 hits on bits 3..7 (overlapping); CNT_W=2 copy saturates at 3
    @(negedge clock);
    reset_n = 1'b0; valid_in = 1'b0; i = 1'b0; clear = 1'b0; cfg_we = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      valid_in = 1'b1; i = 1'b1;
      #1;
      check($sformatf("ones%0d_hit0", k), 32'(hit[0]), (k >= 3) ? 32'd1 : 32'd0);
      check($sformatf("ones%0d_sat_hit0", k), 32'(hit2[0]), (k >= 3) ? 32'd1 : 32'd0);
      @(posedge clock);
      #1;
      $display("ones %0d hit=%b c0=%0d sat_c0=%0d", k, hit, count[7:0], count2[1:0]);
      if (k == 5) check("ones5_count0", 32'(count[7:0]), 32'd3);
    end
    check("ones_count0", 32'(count[7:0]), 32'd5);
    check("ones_sat_count0", 32'(count2[1:0]), 32'd3);
    check("ones_sat_seen", 32'(seen2), 32'b01);
    @(negedge clock);
    valid_in = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_pattern_detector.md
MULTI_PATTERN_DETECTOR -- requirements
Module: multi_pattern_detector

Interface
REQ-001 Parameter PAT_LEN, default 3: pattern length in bits; legal range 2..16.
REQ-002 Parameter NUM_PAT, default 2: number of independent pattern lanes; legal range 1..8.
REQ-003 Parameter CNT_W, default 8: width of each per-lane match counter.
REQ-004 Parameter RESET_PATTERNS, width NUM_PAT*PAT_LEN, default 6'b001_111: lane k reset pattern in bits [k*PAT_LEN +: PAT_LEN], so lane0=111 and lane1=001.
REQ-005 clock  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 i  in  1  serial data bit.
REQ-008 valid_in  in  1  i is sampled only when valid_in=1.
REQ-009 clear  in  1  synchronous clear of the seen and count outputs.
REQ-010 cfg_we  in  1  pattern write strobe.
REQ-011 cfg_idx  in  clog2(NUM_PAT), minimum 1  lane selected for a pattern write.
REQ-012 cfg_pattern  in  PAT_LEN  new pattern value.
REQ-013 hit  out  NUM_PAT  Mealy match pulse per lane, combinational from the current inputs.
REQ-014 seen  out  NUM_PAT  sticky match flag per lane.
REQ-015 count  out  NUM_PAT*CNT_W  saturating match count; lane k occupies [k*CNT_W +: CNT_W].

Function
REQ-016 Bit order: pattern bit PAT_LEN-1 = oldest bit, bit 0 = newest bit (the current i).
REQ-017 History: a PAT_LEN-1 bit shift register; on clock edge with valid_in=1, shifts in i; with valid_in=0, holds.
REQ-018 Fill counter: counts accepted bits and saturates at PAT_LEN-1; history_full = (fill == PAT_LEN-1).
REQ-019 hit[k] = valid_in & history_full & ({history, i} == pattern[k]); no register in this path, so latency is zero cycles.
REQ-020 Matches may overlap: every accepted bit that completes a pattern asserts hit, including bits inside a previous match.
REQ-021 On a clock edge where hit[k]=1: seen[k] is set to 1, and count[k] increments, saturating at 2^CNT_W-1 (no wrap).
REQ-022 seen[k] stays at 1 until clear or reset.
REQ-023 clear=1 at an edge zeroes all seen and count; clear overrides a simultaneous hit. History, fill and patterns are unchanged. The hit output still reflects that cycle's match.
REQ-024 cfg_we=1 at an edge loads pattern[cfg_idx] = cfg_pattern. hit in that same cycle uses the old pattern; the new pattern applies from the next cycle.
REQ-025 A cfg_idx value >= NUM_PAT makes the write a no-op.
REQ-026 A pattern write does not alter that lane's seen, count or the history.

Reset
REQ-027 reset_n low, asynchronously: history=0, fill=0, seen=0, count=0, pattern[k]=RESET_PATTERNS slice k.
REQ-028 While reset_n is low, hit=0 because history_full=0.
REQ-029 After reset deassertion, no lane can hit until PAT_LEN bits have been accepted, including the bit in the current cycle.
REQ-030 Reset asserted mid-stream discards all partial history.

Structure
REQ-031 The shared package holds: the default PAT_LEN, NUM_PAT and CNT_W values, the default RESET_PATTERNS constant, and a count-saturation helper function.
REQ-032 One sub-module, pattern_match_lane, holds one lane: pattern register, comparator, sticky flag and saturating counter.
REQ-033 pattern_match_lane is instantiated NUM_PAT times via generate.
REQ-034 The top level owns only the history shift register, the fill counter and the cfg decode.

Verification
REQ-035 Reset, then valid bits 0,0,1 -> hit[1] pulses on the third bit only; then seen=2'b10, count lane1=1, hit[0] never asserted.
REQ-036 Reset, then the first valid bit is 1 -> no hit on any lane (history not full, despite the zero reset history).
REQ-037 Valid bits 1,1,1,1,1 -> hit[0] on bits 3, 4 and 5; count lane0=3. With CNT_W=2 and 5 matches -> count lane0=3 (saturated).
REQ-038 Sequence 1,1, then one cycle with valid_in=0 and i=0, then 1 -> hit[0] on the final bit; the invalid bit is ignored.
REQ-039 cfg write lane0=101, then stream 1,0,1 -> hit[0] on the third bit. Then clear coincident with a new 101 match -> hit[0]=1 that cycle; seen[0]=0 and count lane0=0 after the edge.
REQ-040 Stream 0,0, assert reset_n low for one cycle, release, then stream 1 -> no hit[1]; fill restarts at 0.
